// File: rtl/hi_lo_muldiv_if.sv
// Request/result bundle for the HI/LO multiply-divide unit.
// The master issues start/op/a/b; the slave reports busy/done and the HI/LO registers.
interface hi_lo_muldiv_if #(parameter int WIDTH = 32);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;

   modport master (output start, op, a, b, input busy, done, hi_out, lo_out);
   modport slave  (input start, op, a, b, output busy, done, hi_out, lo_out);
endinterface

// File: rtl/hi_lo_muldiv.sv
// Iterative HI/LO multiply/divide unit (MIPS-style MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Multiply and divide work on operand magnitudes, one bit per enabled cycle,
// and the sign of the results is fixed up as HI/LO are loaded on the last iteration.
module hi_lo_muldiv #(
   parameter int WIDTH = 32
) (
   input logic           clk,
   input logic           reset,
   input logic           clk_enable,
   hi_lo_muldiv_if.slave bus
);

   localparam int               CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, next_state;
   logic [CNT_W-1:0] count;

   logic [WIDTH-1:0] hi_reg, lo_reg;
   logic             done_reg;

   // Working registers: acc is the upper half (partial product / remainder),
   // shreg the lower half (multiplier / dividend shifting into quotient),
   // opnd the captured multiplicand or divisor magnitude.
   logic [WIDTH-1:0] acc, shreg, opnd;
   logic             is_div, neg_q, neg_r, div_zero;

   logic             op_legal, accept, accept_mt, accept_iter, finish;
   logic             op_signed;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   mul_sum, div_shift;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] acc_next, shreg_next;
   logic [2*WIDTH-1:0] prod, prod_signed;
   logic [WIDTH-1:0] quot_final, rem_final;

   // Request decode and next-state selection for the IDLE/RUN controller.
   always_comb begin
      op_legal    = (bus.op <= 3'b101);
      accept      = bus.start && op_legal && (state == IDLE);
      accept_mt   = accept && bus.op[2];
      accept_iter = accept && !bus.op[2];
      finish      = (state == RUN) && (count == LAST);
      next_state  = state;
      if (accept_iter) begin
         next_state = RUN;
      end else if (finish) begin
         next_state = IDLE;
      end
   end

   // Operand magnitudes and one shift-add / restoring-subtract step, plus the sign-corrected results.
   always_comb begin
      op_signed  = !bus.op[0];
      a_mag      = (op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      b_mag      = (op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

      addend     = shreg[0] ? opnd : {WIDTH{1'b0}};
      mul_sum    = {1'b0, acc} + {1'b0, addend};
      div_shift  = {acc, shreg[WIDTH-1]};
      div_ge     = (div_shift >= {1'b0, opnd});
      div_diff   = div_shift[WIDTH-1:0] - opnd;

      acc_next   = acc;
      shreg_next = shreg;
      if (is_div) begin
         acc_next   = div_ge ? div_diff : div_shift[WIDTH-1:0];
         shreg_next = {shreg[WIDTH-2:0], div_ge};
      end else begin
         acc_next   = mul_sum[WIDTH:1];
         shreg_next = {mul_sum[0], shreg[WIDTH-1:1]};
      end

      prod        = {acc_next, shreg_next};
      prod_signed = neg_q ? -prod : prod;
      quot_final  = div_zero ? {WIDTH{1'b1}} : (neg_q ? -shreg_next : shreg_next);
      rem_final   = neg_r ? -acc_next : acc_next;
   end

   // Controller state and iteration counter; reset wins over everything, clk_enable freezes both.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         count <= '0;
      end else if (clk_enable) begin
         state <= next_state;
         if (accept_iter || finish) begin
            count <= '0;
         end else if (state == RUN) begin
            count <= count + CNT_W'(1);
         end
      end
   end

   // Datapath: operand capture, per-cycle iteration, and HI/LO/done updates.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hi_reg   <= '0;
         lo_reg   <= '0;
         done_reg <= 1'b0;
         acc      <= '0;
         shreg    <= '0;
         opnd     <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
      end else if (clk_enable) begin
         done_reg <= 1'b0;
         if (accept_mt) begin
            if (bus.op[0]) begin
               lo_reg <= bus.a;
            end else begin
               hi_reg <= bus.a;
            end
            done_reg <= 1'b1;
         end else if (accept_iter) begin
            acc      <= '0;
            shreg    <= a_mag;
            opnd     <= b_mag;
            is_div   <= bus.op[1];
            neg_q    <= op_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r    <= op_signed && bus.a[WIDTH-1];
            div_zero <= (bus.b == '0);
         end else if (state == RUN) begin
            acc   <= acc_next;
            shreg <= shreg_next;
            if (finish) begin
               if (is_div) begin
                  hi_reg <= rem_final;
                  lo_reg <= quot_final;
               end else begin
                  hi_reg <= prod_signed[2*WIDTH-1:WIDTH];
                  lo_reg <= prod_signed[WIDTH-1:0];
               end
               done_reg <= 1'b1;
            end
         end
      end
   end

   assign bus.busy   = (state == RUN);
   assign bus.done   = done_reg;
   assign bus.hi_out = hi_reg;
   assign bus.lo_out = lo_reg;

endmodule

// File: tb/tb_hi_lo_muldiv.sv
// Self-checking bench for hi_lo_muldiv: directed corner cases followed by randomized
// transactions compared against a plain-arithmetic reference model.
module tb_hi_lo_muldiv;

   localparam int WIDTH = 32;

   logic clk = 1'b0;
   logic reset;
   logic clk_enable;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   hi_lo_muldiv_if #(.WIDTH(WIDTH)) bus ();

   hi_lo_muldiv #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .clk_enable (clk_enable),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Reference behaviour computed directly from the arithmetic definition of each op.
   function automatic void refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] old_hi, input logic [31:0] old_lo,
                                    output logic [31:0] hi, output logic [31:0] lo);
      longint      sp;
      logic [63:0] up;
      int          sa, sb;
      sa = a;
      sb = b;
      hi = old_hi;
      lo = old_lo;
      case (op)
         3'd0: begin
            sp = longint'(sa) * longint'(sb);
            {hi, lo} = sp;
         end
         3'd1: begin
            up = {32'b0, a} * {32'b0, b};
            {hi, lo} = up;
         end
         3'd2: begin
            if (b == 32'd0) begin
               lo = 32'hFFFF_FFFF;
               hi = a;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               lo = 32'h8000_0000;
               hi = 32'd0;
            end else begin
               lo = sa / sb;
               hi = sa % sb;
            end
         end
         3'd3: begin
            if (b == 32'd0) begin
               lo = 32'hFFFF_FFFF;
               hi = a;
            end else begin
               lo = a / b;
               hi = a % b;
            end
         end
         3'd4: hi = a;
         3'd5: lo = a;
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Issues one request from IDLE, follows it to completion and checks results, busy and done.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input int stall_at, input int stall_len, input bit noise,
                                input string tag);
      logic [31:0] nh, nl;
      int          edges;
      bit          held_ok;
      refModel(op, a, b, exp_hi, exp_lo, nh, nl);
      bus.start  = 1'b1;
      bus.op     = op;
      bus.a      = a;
      bus.b      = b;
      clk_enable = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.op    = 3'($urandom_range(0, 7));
      bus.a     = $urandom;
      bus.b     = $urandom;
      if (op[2]) begin
         checkOutput({tag, " busy"}, 64'(bus.busy), 64'd0);
         checkOutput({tag, " done"}, 64'(bus.done), 64'd1);
      end else begin
         checkOutput({tag, " busy@accept"}, 64'(bus.busy), 64'd1);
         held_ok = 1'b1;
         edges   = 0;
         for (int e = 1; e <= WIDTH + stall_len + 20; e++) begin
            clk_enable = !(e >= stall_at && e < stall_at + stall_len);
            bus.start  = noise && ($urandom_range(0, 3) == 0);
            bus.op     = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done) begin
               edges = e;
               break;
            end
            if (!bus.busy || bus.hi_out !== exp_hi || bus.lo_out !== exp_lo) held_ok = 1'b0;
         end
         clk_enable = 1'b1;
         checkOutput({tag, " hold"}, 64'(held_ok), 64'd1);
         checkOutput({tag, " edges"}, 64'(edges), 64'(WIDTH + stall_len));
         checkOutput({tag, " busy@done"}, 64'(bus.busy), 64'd0);
      end
      checkOutput({tag, " hi"}, 64'(bus.hi_out), 64'(nh));
      checkOutput({tag, " lo"}, 64'(bus.lo_out), 64'(nl));
      exp_hi = nh;
      exp_lo = nl;
      @(posedge clk); #1;
      checkOutput({tag, " done pulse"}, 64'(bus.done), 64'd0);
   endtask

   initial begin
      bit saw_done;
      logic [2:0] rop;
      int s_at, s_len;

      bus.start  = 1'b0;
      bus.op     = 3'd0;
      bus.a      = '0;
      bus.b      = '0;
      clk_enable = 1'b0;
      reset      = 1'b0;

      // Reset with clk_enable low and a competing MTHI request.
      bus.start = 1'b1;
      bus.op    = 3'd4;
      bus.a     = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset hi", 64'(bus.hi_out), 64'd0);
      checkOutput("reset lo", 64'(bus.lo_out), 64'd0);
      checkOutput("reset busy", 64'(bus.busy), 64'd0);
      checkOutput("reset done", 64'(bus.done), 64'd0);
      bus.start  = 1'b0;
      reset      = 1'b1;
      clk_enable = 1'b1;
      @(posedge clk); #1;

      applyStimulus(3'd0, 32'hFFFF_FFFE, 32'd3, 0, 0, 1'b0, "mult -2*3");
      applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0, "multu max");
      applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0, "div -7/2");
      applyStimulus(3'd3, 32'd7, 32'd0, 0, 0, 1'b0, "divu 7/0");
      applyStimulus(3'd4, 32'h1234_5678, 32'd0, 0, 0, 1'b0, "mthi");
      applyStimulus(3'd0, 32'd12345, 32'hFFFF_FF00, 0, 0, 1'b1, "mult noisy");
      applyStimulus(3'd3, 32'd100, 32'd7, 10, 5, 1'b0, "divu stall");
      applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0, "div minneg/-1");
      applyStimulus(3'd2, 32'hFFFF_FF9C, 32'd0, 0, 0, 1'b0, "div neg/0");
      applyStimulus(3'd2, 32'd7, 32'hFFFF_FFFE, 0, 0, 1'b0, "div 7/-2");

      // Illegal op codes must be ignored entirely.
      for (int k = 6; k <= 7; k++) begin
         bus.start = 1'b1;
         bus.op    = 3'(k);
         bus.a     = 32'hCAFE_0000;
         bus.b     = 32'd3;
         @(posedge clk); #1;
         bus.start = 1'b0;
         checkOutput("illegal done", 64'(bus.done), 64'd0);
         checkOutput("illegal busy", 64'(bus.busy), 64'd0);
         checkOutput("illegal hi", 64'(bus.hi_out), 64'(exp_hi));
         checkOutput("illegal lo", 64'(bus.lo_out), 64'(exp_lo));
      end

      // done must hold while stalled, then clear.
      bus.start = 1'b1;
      bus.op    = 3'd5;
      bus.a     = 32'hA5A5_5A5A;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      exp_lo     = 32'hA5A5_5A5A;
      clk_enable = 1'b0;
      @(posedge clk); #1;
      checkOutput("stall done held", 64'(bus.done), 64'd1);
      checkOutput("stall lo", 64'(bus.lo_out), 64'(exp_lo));
      clk_enable = 1'b1;
      @(posedge clk); #1;
      checkOutput("stall done clear", 64'(bus.done), 64'd0);

      // Back-to-back: a new request accepted on the edge that ends the done cycle.
      bus.start = 1'b1;
      bus.op    = 3'd4;
      bus.a     = 32'h0BAD_F00D;
      @(posedge clk); #1;
      bus.op = 3'd5;
      bus.a  = 32'h1357_9BDF;
      @(posedge clk); #1;
      bus.start = 1'b0;
      exp_hi    = 32'h0BAD_F00D;
      exp_lo    = 32'h1357_9BDF;
      checkOutput("b2b done", 64'(bus.done), 64'd1);
      checkOutput("b2b hi", 64'(bus.hi_out), 64'(exp_hi));
      checkOutput("b2b lo", 64'(bus.lo_out), 64'(exp_lo));
      @(posedge clk); #1;

      // Reset on edge 10 of a MULT aborts it with no done pulse.
      bus.start = 1'b1;
      bus.op    = 3'd0;
      bus.a     = 32'd1000;
      bus.b     = 32'd2000;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      reset  = 1'b1;
      exp_hi = '0;
      exp_lo = '0;
      checkOutput("abort hi", 64'(bus.hi_out), 64'd0);
      checkOutput("abort lo", 64'(bus.lo_out), 64'd0);
      checkOutput("abort busy", 64'(bus.busy), 64'd0);
      saw_done = bus.done;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) saw_done = 1'b1;
      end
      checkOutput("abort quiet", 64'(saw_done), 64'd0);

      // Randomized transactions against the reference model.
      for (int n = 0; n < 60; n++) begin
         rop   = 3'($urandom_range(0, 5));
         s_at  = 0;
         s_len = 0;
         if ($urandom_range(0, 1) == 1) begin
            s_at  = $urandom_range(1, WIDTH - 1);
            s_len = $urandom_range(1, 4);
         end
         applyStimulus(rop, pickOperand(), pickOperand(), s_at, s_len,
                       1'($urandom_range(0, 1)), $sformatf("rand%0d op%0d", n, rop));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hi_lo_muldiv.md
HI_LO_MULDIV -- requirements
Module: hi_lo_muldiv

Interface
REQ-001 Parameter: WIDTH, default 32, operand and HI/LO register width; legal values are even and 8 or greater.
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset; sampled on the clk rising edge.
REQ-004 Port: clk_enable  input  1  global stall; when 0, all internal state holds.
REQ-005 Port: start  input  1  request strobe, sampled with op/a/b.
REQ-006 Port: op  input  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 illegal.
REQ-007 Port: a  input  WIDTH  first operand (multiplicand, dividend, or MTHI/MTLO data).
REQ-008 Port: b  input  WIDTH  second operand (multiplier or divisor).
REQ-009 Port: busy  output  1  iterative operation in progress.
REQ-010 Port: done  output  1  one-cycle pulse: HI/LO were updated on the preceding edge.
REQ-011 Port: hi_out  output  WIDTH  current HI register value.
REQ-012 Port: lo_out  output  WIDTH  current LO register value.

Function
REQ-013 FSM states SHALL be IDLE and RUN plus an iteration counter of ceil(log2(WIDTH+1)) bits.
REQ-014 A request SHALL be accepted on an edge where clk_enable=1, reset=1, start=1, state=IDLE and op is legal.
REQ-015 start while RUN SHALL be ignored: no queuing, no effect on the operation in progress.
REQ-016 start with an illegal op SHALL be ignored: no state change, no done pulse.
REQ-017 MTHI/MTLO SHALL write a to HI/LO on the accepting edge; busy stays 0; done=1 for the following cycle.
REQ-018 MULT/MULTU/DIV/DIVU SHALL enter RUN on the accepting edge (edge 0), with busy=1 from edge 0.
REQ-019 Each enabled edge in RUN SHALL perform one iteration; on edge WIDTH, HI/LO SHALL be loaded, state returns to IDLE, busy falls to 0 and done=1 for one cycle.
REQ-020 hi_out/lo_out SHALL hold their prior values throughout RUN; partial results are never visible.
REQ-021 MULT/MULTU: {HI,LO} SHALL equal the 2*WIDTH-bit signed/unsigned product of a and b.
REQ-022 DIV/DIVU: LO SHALL be the quotient and HI the remainder, signed or unsigned per op.
REQ-023 Signed division SHALL truncate the quotient toward zero; the remainder takes the sign of the dividend.
REQ-024 Divide by zero (b=0), signed or unsigned: LO SHALL be all ones and HI SHALL equal a.
REQ-025 Signed most-negative / -1: LO SHALL be the most-negative value and HI SHALL be 0.
REQ-026 Operands SHALL be captured at acceptance; changes to a/b/op during RUN have no effect.
REQ-027 clk_enable=0 SHALL freeze state, counter, HI, LO, busy and done; completion is delayed by one edge per stalled cycle.
REQ-028 A new request MAY be accepted on the edge that ends the done cycle (state=IDLE).
REQ-029 In a single-cycle MTHI/MTLO, HI and LO SHALL be independent: a write to one never blocks or alters the other.

Reset
REQ-030 On any edge with reset=0, regardless of clk_enable: HI=0, LO=0, busy=0, done=0, state=IDLE, counter=0.
REQ-031 Reset during RUN SHALL abort the operation with no done pulse and leave HI/LO at 0.
REQ-032 Reset SHALL take priority over start on the same edge.

Verification (WIDTH=32)
REQ-033 MULT a=0xFFFFFFFE, b=3 -> after 32 edges: HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy high exactly 32 cycles; done single-cycle.
REQ-034 MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-035 DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU a=7, b=0 -> LO=0xFFFFFFFF, HI=0x00000007.
REQ-036 MTHI a=0x12345678 -> hi_out=0x12345678 next cycle, LO unchanged, busy never 1, done pulses once; a second start (MTLO) issued during a later MULT -> ignored, LO unchanged.
REQ-037 reset=0 on edge 10 of a MULT -> HI=LO=0, busy=0, done never asserted.
REQ-038 DIVU a=100, b=7 with clk_enable=0 for 5 cycles mid-operation -> done after 37 edges, LO=14, HI=2.
